// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
//   Shared definitions for the RAM port arbiter and its grant selector.
//   - state_t : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   - GNT_CPU / GNT_PNL : requester ids carried on grant_id and last_grant
//   - CNT_W   : width of the access-cycle counter (covers MEM_LAT up to 15)
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_PNL = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational two-way grant selector.
//   Ports:
//     cpu_req    in   CPU request (already qualified)
//     pnl_req    in   panel request (already qualified)
//     prio_mode  in   1 = CPU always wins a tie, 0 = alternate on ties
//     last_grant in   id of the requester served most recently
//     valid      out  at least one request present
//     pick       out  id of the winner (GNT_CPU / GNT_PNL)
// ---------------------------------------------------------------------------
module rr_pick
   import ram_port_arbiter_pkg::*;
(
   input  logic cpu_req,
   input  logic pnl_req,
   input  logic prio_mode,
   input  logic last_grant,
   output logic valid,
   output logic pick
);

   // NOTE: every output gets a default before any branch so no latch is inferred.
   always_comb begin
      valid = cpu_req | pnl_req;
      pick  = GNT_CPU;
      if (cpu_req && pnl_req) begin
         // On a tie in round-robin mode the side not served last goes next.
         pick = prio_mode ? GNT_CPU : ~last_grant;
      end else if (pnl_req) begin
         pick = GNT_PNL;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Serialises CPU and front-panel accesses onto the single-port RAM.
//   Each access holds address/data/strobe for MEM_LAT cycles, samples read
//   data on the last of them, then pulses the owner's ack for one cycle.
//   Ports:
//     clk, rst                         clock, synchronous active-low reset
//     panel_en                         panel requests honoured only when high
//     cpu_req/we/addr/wdata, cpu_ack   CPU request side
//     cpu_hold                         high while the panel owns the RAM
//     pnl_req/we/addr/wdata, pnl_ack   panel request side
//     rdata                            last read data (held until next read)
//     ram_read/write/addr/wdata/rdata  RAM port
//     busy                             FSM not in IDLE
//     grant_id                         owner of current or most recent access
// ---------------------------------------------------------------------------
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int MEM_LAT      = 2,
   parameter int CPU_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              panel_en,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_hold,
   input  logic              pnl_req,
   input  logic              pnl_we,
   input  logic [ADDR_W-1:0] pnl_addr,
   input  logic [DATA_W-1:0] pnl_wdata,
   output logic              pnl_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              grant_id
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               grant_q;
   logic               last_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;

   logic               pick_valid;
   logic               pick_id;

   rr_pick u_pick (
      .cpu_req    (cpu_req),
      .pnl_req    (pnl_req & panel_en),
      .prio_mode  (CPU_PRIORITY != 0),
      .last_grant (last_q),
      .valid      (pick_valid),
      .pick       (pick_id)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_valid) state_d = ACCESS;
         ACCESS:  if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= GNT_CPU;
         last_q  <= GNT_PNL;   // first tie after reset goes to the CPU
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick_id;
                  we_q    <= (pick_id == GNT_PNL) ? pnl_we    : cpu_we;
                  addr_q  <= (pick_id == GNT_PNL) ? pnl_addr  : cpu_addr;
                  wdata_q <= (pick_id == GNT_PNL) ? pnl_wdata : cpu_wdata;
                  cnt_q   <= CNT_W'(MEM_LAT - 1);
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  if (!we_q) rdata_q <= ram_rdata;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE:    last_q <= grant_q;
            default: ;
         endcase
      end
   end

   // All outputs decode registered state only, so they are glitch-free and
   // take effect one cycle after the deciding edge.
   assign busy      = (state_q != IDLE);
   assign ram_read  = (state_q == ACCESS) & ~we_q;
   assign ram_write = (state_q == ACCESS) &  we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign rdata     = rdata_q;
   assign grant_id  = grant_q;
   assign cpu_ack   = (state_q == DONE) & (grant_q == GNT_CPU);
   assign pnl_ack   = (state_q == DONE) & (grant_q == GNT_PNL);
   assign cpu_hold  = busy & (grant_q == GNT_PNL);

endmodule
